// File: rtl/payload_engine_sched.sv
// Payload scheduler for the match-engine bank: streams one packet's bytes to the
// shared char-class decoder, drives engine clear/enable, waits for the engine
// pipeline to settle and hands the per-engine match vector downstream.
module payload_engine_sched #(
  parameter int unsigned NUM_ENG   = 16,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned MAX_LEN   = 1514,
  parameter int unsigned LEN_W     = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [7:0]         char_byte,
  output logic               eng_en,
  output logic               eng_sod,
  input  logic [NUM_ENG-1:0] eng_match,
  output logic [NUM_ENG-1:0] m_match,
  output logic [LEN_W-1:0]   m_len,
  output logic               m_trunc,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy
);

  localparam logic [LEN_W-1:0] MaxLen    = LEN_W'(MAX_LEN);
  localparam logic [3:0]       DrainLoad = 4'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StReport} state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 trunc_q, trunc_d;
  logic [3:0]           drain_cnt_q, drain_cnt_d;
  logic [7:0]           char_byte_q, char_byte_d;
  logic                 eng_en_q, eng_en_d;
  logic                 eng_sod_q, eng_sod_d;
  logic [NUM_ENG-1:0]   m_match_q, m_match_d;
  logic [LEN_W-1:0]     m_len_q, m_len_d;
  logic                 m_trunc_q, m_trunc_d;
  logic                 m_valid_q, m_valid_d;
  logic                 busy_q, busy_d;

  // Next-state, counters and registered-output next values
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    trunc_d     = trunc_q;
    drain_cnt_d = drain_cnt_q;
    char_byte_d = char_byte_q;
    eng_en_d    = 1'b0;
    m_match_d   = m_match_q;
    m_len_d     = m_len_q;
    m_trunc_d   = m_trunc_q;
    m_valid_d   = m_valid_q;
    s_ready     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_valid) state_d = StScan;
      end
      StScan: begin
        s_ready = 1'b1;
        if (s_valid) begin
          char_byte_d = s_data;
          // Bytes past MAX_LEN are swallowed without clocking the engines
          if (len_q < MaxLen) begin
            eng_en_d = 1'b1;
            len_d    = len_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          if (s_last) begin
            state_d     = StDrain;
            drain_cnt_d = DrainLoad;
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == 4'd0) begin
          m_match_d = eng_match;
          m_len_d   = len_q;
          m_trunc_d = trunc_q;
          m_valid_d = 1'b1;
          state_d   = StReport;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      StReport: begin
        // m_valid is always high here, so m_ready alone completes the handshake
        if (m_ready) begin
          m_valid_d = 1'b0;
          len_d     = '0;
          trunc_d   = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Engines are held clear whenever no packet is being scanned or drained
    eng_sod_d = (state_d == StIdle) || (state_d == StReport);
    busy_d    = (state_d != StIdle);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      trunc_q     <= 1'b0;
      drain_cnt_q <= '0;
      char_byte_q <= '0;
      eng_en_q    <= 1'b0;
      eng_sod_q   <= 1'b1;
      m_match_q   <= '0;
      m_len_q     <= '0;
      m_trunc_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      trunc_q     <= trunc_d;
      drain_cnt_q <= drain_cnt_d;
      char_byte_q <= char_byte_d;
      eng_en_q    <= eng_en_d;
      eng_sod_q   <= eng_sod_d;
      m_match_q   <= m_match_d;
      m_len_q     <= m_len_d;
      m_trunc_q   <= m_trunc_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign char_byte = char_byte_q;
  assign eng_en    = eng_en_q;
  assign eng_sod   = eng_sod_q;
  assign m_match   = m_match_q;
  assign m_len     = m_len_q;
  assign m_trunc   = m_trunc_q;
  assign m_valid   = m_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_payload_engine_sched.sv
// Bench for payload_engine_sched: a behavioural engine bank answers the DUT's
// char/enable/clear outputs; a substring-search model predicts each result.
module tb_payload_engine_sched;

  localparam int NE = 16;
  localparam int DC = 2;
  localparam int ML = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [7:0]    char_byte;
  logic          eng_en;
  logic          eng_sod;
  logic [NE-1:0] eng_match;
  logic [NE-1:0] m_match;
  logic [LW-1:0] m_len;
  logic          m_trunc;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;

  payload_engine_sched #(
    .NUM_ENG  (NE),
    .DRAIN_CYC(DC),
    .MAX_LEN  (ML),
    .LEN_W    (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .char_byte(char_byte),
    .eng_en   (eng_en),
    .eng_sod  (eng_sod),
    .eng_match(eng_match),
    .m_match  (m_match),
    .m_len    (m_len),
    .m_trunc  (m_trunc),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // ---------------- engine bank (environment) ----------------
  logic [31:0]   pat [NE];
  int            plen[NE];
  logic [31:0]   hist[NE];
  logic [NE-1:0] sticky;
  assign eng_match = sticky;

  function automatic logic [31:0] pmask(input int n);
    return (n >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NE; k++) hist[k] <= '0;
      sticky <= '0;
    end else if (eng_sod) begin
      for (int k = 0; k < NE; k++) hist[k] <= '0;
      sticky <= '0;
    end else if (eng_en) begin
      for (int k = 0; k < NE; k++) begin
        hist[k] <= {hist[k][23:0], char_byte};
        if (({hist[k][23:0], char_byte} & pmask(plen[k])) == pat[k]) sticky[k] <= 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [NE-1:0] match;
    int            len;
    int            trunc;
    int            en;
  } exp_t;

  exp_t        exp_q[$];
  byte unsigned pkt_q[$];
  int          gap_q[$];

  function automatic exp_t model();
    exp_t e;
    int n = pkt_q.size();
    int s = (n > ML) ? ML : n;
    e.len   = s;
    e.trunc = (n > ML) ? 1 : 0;
    e.en    = s;
    e.match = '0;
    for (int k = 0; k < NE; k++) begin
      for (int st = 0; st + plen[k] <= s; st++) begin
        bit ok = 1'b1;
        for (int j = 0; j < plen[k]; j++)
          if (pkt_q[st + j] != pat[k][8 * (plen[k] - 1 - j) +: 8]) ok = 1'b0;
        if (ok) e.match[k] = 1'b1;
      end
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  int last_cyc = 0;

  task automatic load_str(input string s);
    pkt_q.delete();
    gap_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      pkt_q.push_back(s[i]);
      gap_q.push_back(0);
    end
  endtask

  task automatic send_pkt();
    int n = pkt_q.size();
    exp_q.push_back(model());
    for (int i = 0; i < n; i++) begin
      int t = 0;
      if (gap_q[i] > 0) begin
        s_valid = 1'b0;
        repeat (gap_q[i]) begin
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = pkt_q[i];
      s_last  = (i == n - 1);
      forever begin
        @(negedge clk);
        if (s_ready) break;
        t++;
        if (t > 300) begin
          checks++;
          errors++;
          $display("FAIL s_ready_timeout: got 0 expected 1 after %0d cycles", t);
          finish_sim();
        end
      end
      @(posedge clk);
      #1;
      if (i == n - 1) last_cyc = cyc;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 || m_valid) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 500) begin
        checks++;
        errors++;
        $display("FAIL result_timeout: got %0d pending expected 0", exp_q.size());
        finish_sim();
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // m_ready: 0 random, 1 high, 2 low
  int rdy_mode = 1;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0)      m_ready = 1'($urandom_range(0, 1));
      else if (rdy_mode == 1) m_ready = 1'b1;
      else                    m_ready = 1'b0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int            en_cnt = 0;
    logic [7:0]    prev_ch = '0;
    logic          prev_mv = 1'b0;
    logic          prev_rdy = 1'b0;
    logic [NE-1:0] prev_match = '0;
    logic [LW-1:0] prev_len = '0;
    logic          prev_trunc = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_cnt   = 0;
        prev_ch  = char_byte;
        prev_mv  = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (m_valid) begin
          chk("report_s_ready", s_ready, 0);
          chk("report_sod", eng_sod, 1);
        end else begin
          chk("sod_vs_busy", eng_sod, !busy);
        end
        if (!eng_en && en_cnt < ML) chk("char_hold", char_byte, prev_ch);
        if (eng_en) en_cnt++;
        if (prev_mv && !prev_rdy) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_match", m_match, prev_match);
          chk("hold_len", m_len, prev_len);
          chk("hold_trunc", m_trunc, prev_trunc);
        end
        if (m_valid && !prev_mv) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got m_valid=1 expected no result");
          end else begin
            e = exp_q.pop_front();
            chk("m_match", m_match, e.match);
            chk("m_len", m_len, e.len);
            chk("m_trunc", m_trunc, e.trunc);
            chk("eng_en_pulses", en_cnt, e.en);
            chk("latency", cyc - last_cyc, DC);
          end
          en_cnt = 0;
        end
        prev_mv    = m_valid;
        prev_rdy   = m_ready;
        prev_match = m_match;
        prev_len   = m_len;
        prev_trunc = m_trunc;
        prev_ch    = char_byte;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_char_byte"}, char_byte, 0);
    chk({tag, "_eng_en"}, eng_en, 0);
    chk({tag, "_eng_sod"}, eng_sod, 1);
    chk({tag, "_m_match"}, m_match, 0);
    chk({tag, "_m_len"}, m_len, 0);
    chk({tag, "_m_trunc"}, m_trunc, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_sim();
  end

  // ---------------- stimulus ----------------
  initial begin
    string alpha;
    alpha = "abcdx";
    pat[0] = 32'h0061_6263; plen[0] = 3;  // "abc"
    pat[1] = 32'h0061_6264; plen[1] = 3;  // "abd"
    pat[2] = 32'h0000_0078; plen[2] = 1;  // "x"
    for (int k = 3; k < NE; k++) begin
      plen[k] = $urandom_range(1, 3);
      pat[k]  = '0;
      for (int j = 0; j < plen[k]; j++)
        pat[k] = {pat[k][23:0], 8'(8'h61 + $urandom_range(0, 3))};
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    load_str("xabc"); send_pkt(); wait_drain();
    load_str("xabd"); send_pkt(); wait_drain();
    load_str("abc"); gap_q[2] = 3; send_pkt(); wait_drain();
    load_str("a"); send_pkt(); wait_drain();
    load_str("xxxxxabc"); send_pkt(); wait_drain();
    load_str("xxxxxxabc"); send_pkt(); wait_drain();
    load_str("xxxxxxxabc"); send_pkt(); wait_drain();

    // Result held off while the next packet is already waiting upstream
    rdy_mode = 2;
    load_str("abc");
    send_pkt();
    fork
      begin
        int t = 0;
        while (!m_valid && t < 50) begin
          @(posedge clk);
          #1;
          t++;
        end
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 1;
      end
      begin
        load_str("xabd");
        send_pkt();
      end
    join
    wait_drain();

    // Randomized packets with bubbles and random back-pressure
    rdy_mode = 0;
    repeat (40) begin
      int n = $urandom_range(1, 11);
      pkt_q.delete();
      gap_q.delete();
      for (int i = 0; i < n; i++) begin
        pkt_q.push_back(alpha[$urandom_range(0, 4)]);
        gap_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      send_pkt();
    end
    wait_drain();

    // Reset in the middle of a packet abandons it
    rdy_mode = 1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'h61 + i);
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("no_result_after_rst", m_valid, 0);

    load_str("xabc"); send_pkt(); wait_drain();

    finish_sim();
  end

endmodule
